// File: rtl/iiitb_seq_pkg.sv
// Shared types and helpers for the serial pattern detector.
// State enum, length bound and length-mask function.
package iiitb_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } seq_state_t;

  localparam int MAX_LEN_LIMIT = 32;

  function automatic logic [MAX_LEN_LIMIT-1:0] len_mask(
    input int len
  );
    logic [MAX_LEN_LIMIT-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LEN_LIMIT; i++) begin
      if (i < len) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/iiitb_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones once reached.
module iiitb_sat_counter
  import iiitb_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // next count: clear wins, then saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iiitb_seq_det.sv
// Runtime-configurable serial pattern detector.
// Optional match counter built when SEQ_DET_COUNT_EN is defined.
module iiitb_seq_det
  import iiitb_seq_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               din,
  input  logic               din_valid,
  input  logic               cfg_we,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               det,
  output logic               cfg_err,
  output logic               busy,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [LEN_W-1:0] L_ONE = LEN_W'(1);
  localparam logic [LEN_W-1:0] L_MAX = LEN_W'(MAX_LEN);

  seq_state_t         state_q, state_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [MAX_LEN-1:0] win_q, win_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               ovl_q, ovl_d;
  logic               det_q, det_d;
  logic               err_q, err_d;
  logic               busy_q;

  logic               wr_ok;
  logic               wr_bad;
  logic               take;
  logic               hit;
  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] cand;

  assign wr_ok  = cfg_we && (cfg_len >= L_ONE)
               && (cfg_len <= L_MAX);
  assign wr_bad = cfg_we && !wr_ok;

  // a legal write steals the cycle's bit
  assign take = din_valid && !wr_ok
             && (state_q != IDLE);

  assign mask = MAX_LEN'(len_mask(32'(len_q)));
  assign cand = MAX_LEN'({win_q, din});
  assign hit  = ((cand ^ pat_q) & mask) == '0;

  // next-state, window and pulse decode
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovl_d   = ovl_q;
    win_d   = win_q;
    fill_d  = fill_q;
    det_d   = 1'b0;
    err_d   = wr_bad;
    if (wr_ok) begin
      pat_d   = cfg_pattern;
      len_d   = cfg_len;
      ovl_d   = cfg_overlap;
      win_d   = '0;
      fill_d  = '0;
      state_d = (cfg_len == L_ONE) ? RUN : FILL;
    end else if (take) begin
      unique case (state_q)
        FILL: begin
          win_d  = cand;
          fill_d = fill_q + L_ONE;
          if (fill_q + L_ONE == len_q - L_ONE)
            state_d = RUN;
        end
        RUN: begin
          det_d = hit;
          if (hit && !ovl_q) begin
            win_d   = '0;
            fill_d  = '0;
            state_d = (len_q == L_ONE) ? RUN : FILL;
          end else begin
            win_d = cand;
            if (fill_q < len_q)
              fill_d = fill_q + L_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  // state and config registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      ovl_q   <= 1'b0;
      win_q   <= '0;
      fill_q  <= '0;
      det_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      win_q   <= win_d;
      fill_q  <= fill_d;
      det_q   <= det_d;
      err_q   <= err_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign det     = det_q;
  assign cfg_err = err_q;
  assign busy    = busy_q;

`ifdef SEQ_DET_COUNT_EN
  iiitb_sat_counter #(
    .W(CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr_i (wr_ok),
    .inc_i (det_d),
    .cnt_o (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_iiitb_seq_det.sv
// Bench for iiitb_seq_det: directed scenarios plus
// random traffic against a bit-history reference model.
module tb_iiitb_seq_det;

  localparam int ML = 8;
  localparam int LW = 4;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          din;
  logic          din_valid;
  logic          cfg_we;
  logic [ML-1:0] cfg_pattern;
  logic [LW-1:0] cfg_len;
  logic          cfg_overlap;
  logic          det;
  logic          cfg_err;
  logic          busy;
  logic [CW-1:0] match_cnt;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  bit          m_cfg;
  bit [ML-1:0] m_pat;
  int          m_len;
  bit          m_ovl;
  bit          hist[$];
  int          m_cnt;
  bit          e_det;
  bit          e_err;

  iiitb_seq_det #(
    .MAX_LEN(ML),
    .LEN_W  (LW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .din_valid  (din_valid),
    .cfg_we     (cfg_we),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .det        (det),
    .cfg_err    (cfg_err),
    .busy       (busy),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  function automatic int exp_cnt();
`ifdef SEQ_DET_COUNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  // predict outputs after the coming edge from the current inputs
  task automatic model();
    int  len;
    bit  match;
    e_det = 1'b0;
    e_err = 1'b0;
    len   = int'(cfg_len);
    if (cfg_we && len >= 1 && len <= ML) begin
      m_cfg = 1'b1;
      m_pat = cfg_pattern;
      m_len = len;
      m_ovl = cfg_overlap;
      m_cnt = 0;
      hist.delete();
    end else begin
      if (cfg_we) e_err = 1'b1;
      if (din_valid && m_cfg) begin
        hist.push_back(din);
        if (hist.size() >= m_len) begin
          match = 1'b1;
          for (int i = 0; i < m_len; i++)
            if (hist[hist.size() - m_len + i] != m_pat[m_len-1-i])
              match = 1'b0;
          if (match) begin
            e_det = 1'b1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            if (!m_ovl) hist.delete();
          end
        end
        if (hist.size() > 40) void'(hist.pop_front());
      end
    end
  endtask

  task automatic check(input string tag);
    tests++;
    assert (det === e_det) else begin
      fails++;
      $error("FAIL %s det: got %b expected %b", tag, det, e_det);
    end
    tests++;
    assert (cfg_err === e_err) else begin
      fails++;
      $error("FAIL %s cfg_err: got %b expected %b", tag, cfg_err, e_err);
    end
    tests++;
    assert (busy === m_cfg) else begin
      fails++;
      $error("FAIL %s busy: got %b expected %b", tag, busy, m_cfg);
    end
    tests++;
    assert (match_cnt === CW'(exp_cnt())) else begin
      fails++;
      $error("FAIL %s match_cnt: got %0d expected %0d",
             tag, match_cnt, exp_cnt());
    end
  endtask

  task automatic check_eq(input string tag, input int got, input int want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic feed(input bit d, input bit v, input string tag);
    din       = d;
    din_valid = v;
    cfg_we    = 1'b0;
    model();
    @(posedge clk);
    #1;
    check(tag);
    if (det === 1'b1) pulses++;
  endtask

  task automatic cfg(input logic [ML-1:0] p, input logic [LW-1:0] l,
                     input bit o, input bit d, input bit v,
                     input string tag);
    din         = d;
    din_valid   = v;
    cfg_we      = 1'b1;
    cfg_pattern = p;
    cfg_len     = l;
    cfg_overlap = o;
    model();
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    check(tag);
    if (det === 1'b1) pulses++;
  endtask

  task automatic do_reset(input string tag);
    din_valid = 1'b0;
    cfg_we    = 1'b0;
    reset     = 1'b1;
    m_cfg     = 1'b0;
    m_cnt     = 0;
    e_det     = 1'b0;
    e_err     = 1'b0;
    hist.delete();
    #1;
    check(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [6:0] s7;
    logic [3:0] s4;
    int         r;
    reset       = 1'b1;
    din         = 1'b0;
    din_valid   = 1'b0;
    cfg_we      = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    m_cfg       = 1'b0;
    m_cnt       = 0;
    #1;
    check("reset_init");
    @(posedge clk);
    #1;
    reset = 1'b0;

    feed(1'b1, 1'b1, "idle_a");
    feed(1'b0, 1'b1, "idle_b");

    // overlapping 1010
    cfg(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0, "cfg_ovl");
    pulses = 0;
    s7 = 7'b1010101;
    for (int i = 6; i >= 0; i--) feed(s7[i], 1'b1, "ovl");
    check_eq("ovl_pulses", pulses, 2);
`ifdef SEQ_DET_COUNT_EN
    check_eq("ovl_cnt", int'(match_cnt), 2);
`else
    check_eq("ovl_cnt", int'(match_cnt), 0);
`endif

    // non-overlapping 1010
    cfg(8'h0A, 4'd4, 1'b0, 1'b0, 1'b0, "cfg_novl");
    pulses = 0;
    for (int i = 6; i >= 0; i--) feed(s7[i], 1'b1, "novl");
    check_eq("novl_pulses", pulses, 1);
    feed(1'b1, 1'b1, "novl_x");
    feed(1'b0, 1'b1, "novl_y");

    // gapped input
    cfg(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0, "cfg_gap");
    pulses = 0;
    s4 = 4'b1010;
    for (int i = 3; i >= 0; i--) begin
      feed(s4[i], 1'b1, "gap_bit");
      for (int k = 0; k < 3; k++)
        feed(1'($urandom), 1'b0, "gap_idle");
    end
    check_eq("gap_pulses", pulses, 1);

    // rejected write keeps config and the bit
    cfg(8'hFF, 4'd0, 1'b0, 1'b1, 1'b1, "bad_len0");
    pulses = 0;
    feed(1'b0, 1'b1, "bad_keep");
    check_eq("bad_keep_pulses", pulses, 1);
    cfg(8'hFF, 4'd9, 1'b0, 1'b0, 1'b0, "bad_len9");

    // write with din_valid drops the bit
    cfg(8'h0A, 4'd4, 1'b1, 1'b1, 1'b1, "wr_drop");
    pulses = 0;
    feed(1'b0, 1'b1, "drop_a");
    feed(1'b1, 1'b1, "drop_b");
    feed(1'b0, 1'b1, "drop_c");
    check_eq("drop_pulses", pulses, 0);

    // single-bit pattern, non-overlap
    cfg(8'h01, 4'd1, 1'b0, 1'b0, 1'b0, "cfg_len1");
    pulses = 0;
    s4 = 4'b1101;
    for (int i = 3; i >= 0; i--) feed(s4[i], 1'b1, "len1");
    check_eq("len1_pulses", pulses, 3);

    // reset mid-stream
    cfg(8'h0A, 4'd4, 1'b1, 1'b0, 1'b0, "cfg_mid");
    feed(1'b1, 1'b1, "mid_a");
    feed(1'b0, 1'b1, "mid_b");
    feed(1'b1, 1'b1, "mid_c");
    do_reset("reset_mid");
    feed(1'b0, 1'b1, "post_reset");

    // saturation
    cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0, "cfg_sat");
    for (int i = 0; i < 6; i++) feed(1'b1, 1'b1, "sat");
`ifdef SEQ_DET_COUNT_EN
    check_eq("sat_cnt", int'(match_cnt), 3);
`else
    check_eq("sat_cnt", int'(match_cnt), 0);
`endif

    // random traffic
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset("rnd_reset");
      end else if (r < 8) begin
        cfg(ML'($urandom),
            (r < 7) ? LW'($urandom_range(1, 4))
                    : LW'($urandom_range(0, 15)),
            1'($urandom), 1'($urandom), 1'($urandom),
            "rnd_cfg");
      end else begin
        feed(1'($urandom), ($urandom_range(0, 3) != 0), "rnd_bit");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
